trigger_unit: RTL and testbench

- Parametrised hardware trigger block: NUM_TRIGGERS sets of mcontrol-style trigger registers (tselect, tdata1, tdata2, tinfo) plus address-match logic.
- Compares instruction-fetch PC and load/store addresses against each trigger, sets sticky hit bits, and emits a registered breakpoint/debug-entry request to the core exception/debug logic.
- CSR access comes from both the decoder (csrrw/csrrs/csrrc) and the debugger abstract-register path.

---
 rtl/trigger_unit.sv | 200 ++++++++++++++++++++
 tb/tb_trigger_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_unit.sv
`default_nettype none
// ============================================================================
// Module   : trigger_unit
// Purpose  : mcontrol-style address-match triggers with CSR/debugger access
//            and a registered breakpoint / debug-entry request.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_TRIGGERS = 4,
  parameter int IDX_W        = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [11:0]           csr_addr,
  input  logic                  valid_mcsr_rd,
  input  logic                  valid_mcsr_wr,
  input  logic                  mcsr_set,
  input  logic                  mcsr_clr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  dbg_mode,
  input  logic                  dbg_reg_access,
  input  logic                  dbg_wr1_rd0,
  input  logic [15:0]           dbg_regno,
  input  logic [DATA_WIDTH-1:0] dbg_write_data,
  output logic [DATA_WIDTH-1:0] dbg_read_data,
  output logic                  dbg_read_data_valid,
  output logic                  dbg_wr,
  input  logic                  priv_m,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  ls_valid,
  input  logic                  ls_store,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  output logic                  trig_hit,
  output logic                  trig_action,
  output logic [IDX_W-1:0]      trig_index
);

  localparam logic [11:0] c_ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] c_ADDR_TDATA1  = 12'h7A1;
  localparam logic [11:0] c_ADDR_TDATA2  = 12'h7A2;
  localparam logic [11:0] c_ADDR_TINFO   = 12'h7A4;
  localparam logic [3:0]  c_TYPE         = 4'd2;

  logic [IDX_W-1:0]      r_tselect;
  logic [NUM_TRIGGERS-1:0] r_dmode, r_hit, r_action, r_m, r_u, r_exe, r_st, r_ld;
  logic [1:0]            r_match  [NUM_TRIGGERS];
  logic [DATA_WIDTH-1:0] r_tdata2 [NUM_TRIGGERS];

  logic                  w_dbg_active, w_dbg_rd, w_wr_en, w_set, w_clr;
  logic [11:0]           w_addr;
  logic [DATA_WIDTH-1:0] w_wd, w_old, w_wv;
  logic [31:0]           w_tdata1 [NUM_TRIGGERS];
  logic [NUM_TRIGGERS-1:0] w_sel_vec, w_fire;
  logic [31:0]           w_sel_t1;
  logic [DATA_WIDTH-1:0] w_sel_t2;
  logic                  w_sel_dmode, w_protect, w_wr_t1, w_wr_t2, w_wr_tsel;
  logic                  w_new_dmode, w_new_action;
  logic [1:0]            w_new_match;
  logic                  w_any, w_fire_act;
  logic [IDX_W-1:0]      w_fire_idx;

  // Debugger access takes over the CSR address and is always a plain write.
  assign w_dbg_active = dbg_reg_access && (dbg_regno <= 16'h0fff);
  assign w_addr       = w_dbg_active ? dbg_regno[11:0] : csr_addr;
  assign dbg_wr       = w_dbg_active & dbg_wr1_rd0;
  assign w_dbg_rd     = w_dbg_active & ~dbg_wr1_rd0;
  assign w_wr_en      = w_dbg_active ? dbg_wr1_rd0 : valid_mcsr_wr;
  assign w_set        = ~w_dbg_active & mcsr_set;
  assign w_clr        = ~w_dbg_active & mcsr_clr;
  assign w_wd         = w_dbg_active ? dbg_write_data : write_data;

  always_comb begin
    w_sel_t1    = '0;
    w_sel_t2    = '0;
    w_sel_dmode = 1'b0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      w_sel_vec[i] = (r_tselect == IDX_W'(i));
      w_tdata1[i]  = {c_TYPE, r_dmode[i], 6'b0, r_hit[i], 4'b0, 3'b0, r_action[i],
                      1'b0, 2'b0, r_match[i], r_m[i], 2'b0, r_u[i], r_exe[i],
                      r_st[i], r_ld[i]};
      if (w_sel_vec[i]) begin
        w_sel_t1    = w_tdata1[i];
        w_sel_t2    = r_tdata2[i];
        w_sel_dmode = r_dmode[i];
      end
    end
  end

  always_comb begin
    case (w_addr)
      c_ADDR_TSELECT: w_old = DATA_WIDTH'(r_tselect);
      c_ADDR_TDATA1:  w_old = DATA_WIDTH'(w_sel_t1);
      c_ADDR_TDATA2:  w_old = w_sel_t2;
      c_ADDR_TINFO:   w_old = DATA_WIDTH'(32'h4);
      default:        w_old = '0;
    endcase
  end

  assign read_data           = (valid_mcsr_rd | w_dbg_rd) ? w_old : '0;
  assign dbg_read_data       = w_dbg_rd ? read_data : '0;
  assign dbg_read_data_valid = w_dbg_rd;

  assign w_wv = w_set ? (w_old | w_wd) : w_clr ? (w_old & ~w_wd) : w_wd;

  // A trigger owned by debug mode is untouchable by ordinary code.
  assign w_protect    = w_sel_dmode & ~dbg_mode & ~w_dbg_active;
  assign w_wr_t1      = w_wr_en && (w_addr == c_ADDR_TDATA1) && !w_protect;
  assign w_wr_t2      = w_wr_en && (w_addr == c_ADDR_TDATA2) && !w_protect;
  assign w_wr_tsel    = w_wr_en && (w_addr == c_ADDR_TSELECT) &&
                        (w_wv < DATA_WIDTH'(NUM_TRIGGERS));
  assign w_new_dmode  = (dbg_mode | w_dbg_active) ? w_wv[27] : w_sel_dmode;
  assign w_new_action = (w_wv[15:12] == 4'd1) & w_new_dmode;

  always_comb begin
    case (w_wv[10:7])
      4'd2:    w_new_match = 2'b10;
      4'd3:    w_new_match = 2'b11;
      default: w_new_match = 2'b00;
    endcase
  end

  function automatic logic addr_match(input logic [1:0] mt,
                                      input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] t);
    case (mt)
      2'b10:   return a >= t;
      2'b11:   return a < t;
      default: return a == t;
    endcase
  endfunction

  always_comb begin
    w_any      = 1'b0;
    w_fire_idx = '0;
    w_fire_act = 1'b0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      w_fire[i] = ((priv_m ? r_m[i] : r_u[i]) & ~dbg_mode) &
                  ((r_exe[i] & if_valid & addr_match(r_match[i], if_pc, r_tdata2[i])) |
                   (r_ld[i] & ls_valid & ~ls_store & addr_match(r_match[i], ls_addr, r_tdata2[i])) |
                   (r_st[i] & ls_valid & ls_store & addr_match(r_match[i], ls_addr, r_tdata2[i])));
    end
    for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
      if (w_fire[i]) begin
        w_any      = 1'b1;
        w_fire_idx = IDX_W'(i);
        w_fire_act = r_action[i];
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_tselect   <= '0;
      r_dmode     <= '0;
      r_hit       <= '0;
      r_action    <= '0;
      r_m         <= '0;
      r_u         <= '0;
      r_exe       <= '0;
      r_st        <= '0;
      r_ld        <= '0;
      trig_hit    <= 1'b0;
      trig_action <= 1'b0;
      trig_index  <= '0;
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        r_match[i]  <= 2'b00;
        r_tdata2[i] <= '0;
      end
    end else begin
      trig_hit <= w_any;
      if (w_any) begin
        trig_index  <= w_fire_idx;
        trig_action <= w_fire_act;
      end
      if (w_wr_tsel) r_tselect <= w_wv[IDX_W-1:0];
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        // A CSR write to this tdata1 overrides a hit set in the same cycle.
        if (w_wr_t1 && w_sel_vec[i]) begin
          r_dmode[i]  <= w_new_dmode;
          r_hit[i]    <= w_wv[20];
          r_action[i] <= w_new_action;
          r_match[i]  <= w_new_match;
          r_m[i]      <= w_wv[6];
          r_u[i]      <= w_wv[3];
          r_exe[i]    <= w_wv[2];
          r_st[i]     <= w_wv[1];
          r_ld[i]     <= w_wv[0];
        end else if (w_fire[i]) begin
          r_hit[i] <= 1'b1;
        end
        if (w_wr_t2 && w_sel_vec[i]) r_tdata2[i] <= w_wv;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_unit
// Purpose  : Scoreboard bench for trigger_unit CSR access and match/fire path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_unit;
  localparam int DW = 32;
  localparam int NT = 4;
  localparam int IW = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic          valid_mcsr_rd = 0, valid_mcsr_wr = 0, mcsr_set = 0, mcsr_clr = 0;
  logic [DW-1:0] write_data = '0, read_data;
  logic          dbg_mode = 0, dbg_reg_access = 0, dbg_wr1_rd0 = 0;
  logic [15:0]   dbg_regno = '0;
  logic [DW-1:0] dbg_write_data = '0, dbg_read_data;
  logic          dbg_read_data_valid, dbg_wr;
  logic          priv_m = 1'b1, if_valid = 0, ls_valid = 0, ls_store = 0;
  logic [DW-1:0] if_pc = '0, ls_addr = '0;
  logic          trig_hit, trig_action;
  logic [IW-1:0] trig_index;

  trigger_unit #(.DATA_WIDTH(DW), .NUM_TRIGGERS(NT), .IDX_W(IW)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .csr_addr(csr_addr),
    .valid_mcsr_rd(valid_mcsr_rd), .valid_mcsr_wr(valid_mcsr_wr),
    .mcsr_set(mcsr_set), .mcsr_clr(mcsr_clr), .write_data(write_data),
    .read_data(read_data), .dbg_mode(dbg_mode), .dbg_reg_access(dbg_reg_access),
    .dbg_wr1_rd0(dbg_wr1_rd0), .dbg_regno(dbg_regno), .dbg_write_data(dbg_write_data),
    .dbg_read_data(dbg_read_data), .dbg_read_data_valid(dbg_read_data_valid),
    .dbg_wr(dbg_wr), .priv_m(priv_m), .if_valid(if_valid), .if_pc(if_pc),
    .ls_valid(ls_valid), .ls_store(ls_store), .ls_addr(ls_addr),
    .trig_hit(trig_hit), .trig_action(trig_action), .trig_index(trig_index)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dut_out(input int sel);
    case (sel)
      0:       return read_data;
      1:       return {31'b0, trig_hit};
      2:       return 32'(trig_index);
      3:       return {31'b0, trig_action};
      4:       return dbg_read_data;
      5:       return {31'b0, dbg_read_data_valid};
      default: return {31'b0, dbg_wr};
    endcase
  endfunction

  always @(negedge cpu_clk) begin : sb_drain
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check_val(e.tag, dut_out(e.sel), e.val);
    end
  end

  task automatic push(input int sel, input int dly, input string tag, input logic [31:0] v);
    exp_t e;
    e.due = cyc + dly; e.sel = sel; e.tag = tag; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic go_cycle();
    @(posedge cpu_clk);
    #1;
    valid_mcsr_rd = 0; valid_mcsr_wr = 0; mcsr_set = 0; mcsr_clr = 0;
    dbg_reg_access = 0; dbg_wr1_rd0 = 0; dbg_mode = 0;
    if_valid = 0; ls_valid = 0; ls_store = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic s, input logic c);
    go_cycle();
    csr_addr = a; write_data = d; valid_mcsr_wr = 1; mcsr_set = s; mcsr_clr = c;
  endtask

  task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    go_cycle();
    csr_addr = a; valid_mcsr_rd = 1;
    push(0, 0, tag, exp);
  endtask

  task automatic dbg_write(input logic [15:0] r, input logic [31:0] d);
    go_cycle();
    dbg_reg_access = 1; dbg_wr1_rd0 = 1; dbg_regno = r; dbg_write_data = d;
    push(6, 0, "dbg_wr", 1);
  endtask

  task automatic dbg_read(input logic [15:0] r, input logic [31:0] exp, input logic vld, input string tag);
    go_cycle();
    dbg_reg_access = 1; dbg_regno = r;
    push(4, 0, tag, exp);
    push(5, 0, "dbg_valid", {31'b0, vld});
  endtask

  task automatic expect_fire(input logic h, input int idx, input logic act, input string tag);
    push(1, 1, {tag, "_hit"}, {31'b0, h});
    push(2, 1, {tag, "_idx"}, 32'(idx));
    push(3, 1, {tag, "_act"}, {31'b0, act});
  endtask

  task automatic fetch(input logic [31:0] pc, input logic dm, input logic h, input int idx,
                       input logic act, input string tag);
    go_cycle();
    dbg_mode = dm; if_valid = 1; if_pc = pc;
    expect_fire(h, idx, act, tag);
  endtask

  task automatic lsu(input logic [31:0] a, input logic st, input logic h, input int idx,
                     input logic act, input string tag);
    go_cycle();
    ls_valid = 1; ls_store = st; ls_addr = a;
    expect_fire(h, idx, act, tag);
  endtask

  initial begin
    repeat (2) @(posedge cpu_clk);
    go_cycle();
    push(1, 0, "rst_hit", 0); push(2, 0, "rst_idx", 0); push(3, 0, "rst_act", 0);
    go_cycle();
    cpu_rstn = 1'b1;

    for (int t = 0; t < NT; t++) begin
      csr_wr(12'h7A0, t, 0, 0);
      csr_rd(12'h7A1, 32'h2000_0000, "tdata1_rst");
      csr_rd(12'h7A2, 32'h0, "tdata2_rst");
    end
    csr_rd(12'h7A4, 32'h4, "tinfo");
    csr_rd(12'h7A3, 32'h0, "tdata3");
    csr_wr(12'h7A0, 5, 0, 0);
    csr_rd(12'h7A0, 3, "tselect_warl5");
    csr_wr(12'h7A0, 4, 0, 0);
    csr_rd(12'h7A0, 3, "tselect_warl4");

    // trigger 1: exact execute match
    csr_wr(12'h7A0, 1, 0, 0);
    csr_wr(12'h7A2, 32'h100, 0, 0);
    csr_wr(12'h7A1, 32'h44, 0, 0);
    csr_rd(12'h7A1, 32'h2000_0044, "t1_cfg");
    fetch(32'h100, 0, 1, 1, 0, "exec1");
    go_cycle();
    push(1, 1, "pulse_end", 0);
    csr_rd(12'h7A1, 32'h2010_0044, "t1_hitbit");

    // triggers 0 (>=) and 2 (<) on loads
    csr_wr(12'h7A0, 0, 0, 0);
    csr_wr(12'h7A2, 32'h2000, 0, 0);
    csr_wr(12'h7A1, 32'h141, 0, 0);
    csr_wr(12'h7A0, 2, 0, 0);
    csr_wr(12'h7A2, 32'h3000, 0, 0);
    csr_wr(12'h7A1, 32'h1C1, 0, 0);
    lsu(32'h2800, 0, 1, 0, 0, "load");
    csr_rd(12'h7A1, 32'h2010_01C1, "t2_hitbit");
    csr_wr(12'h7A0, 0, 0, 0);
    csr_rd(12'h7A1, 32'h2010_0141, "t0_hitbit");
    lsu(32'h2800, 1, 0, 0, 0, "store");
    lsu(32'h1FFF, 0, 1, 2, 0, "load_lt");

    // debugger-owned trigger 3
    dbg_write(16'h07A0, 3);
    dbg_write(16'h07A1, 32'h0800_1044);
    dbg_write(16'h07A2, 32'h400);
    dbg_read(16'h07A1, 32'h2800_1044, 1, "dbg_rd_t1");
    dbg_read(16'h1000, 32'h0, 0, "dbg_rd_out");
    csr_wr(12'h7A1, 32'h0, 0, 0);
    csr_wr(12'h7A2, 32'h0, 0, 0);
    csr_rd(12'h7A1, 32'h2800_1044, "prot_t1");
    csr_rd(12'h7A2, 32'h400, "prot_t2");
    fetch(32'h400, 0, 1, 3, 1, "dmode_fire");
    fetch(32'h400, 1, 0, 3, 1, "in_dbg");

    // WARL fields, set/clear, write-vs-hit
    csr_wr(12'h7A0, 1, 0, 0);
    csr_wr(12'h7A1, 32'h1044, 0, 0);
    csr_rd(12'h7A1, 32'h2000_0044, "action_warl");
    csr_wr(12'h7A1, 32'h2C4, 0, 0);
    csr_rd(12'h7A1, 32'h2000_0044, "match_warl");
    csr_wr(12'h7A1, 32'h1, 1, 0);
    csr_rd(12'h7A1, 32'h2000_0045, "csrrs");
    csr_wr(12'h7A1, 32'h1, 0, 1);
    csr_rd(12'h7A1, 32'h2000_0044, "csrrc");
    fetch(32'h100, 0, 1, 1, 0, "refire");
    go_cycle();
    if_valid = 1; if_pc = 32'h100;
    csr_addr = 12'h7A1; write_data = 32'h0010_0000; valid_mcsr_wr = 1; mcsr_clr = 1;
    expect_fire(1, 1, 0, "fire_clr");
    csr_rd(12'h7A1, 32'h2000_0044, "wr_wins");

    // asynchronous reset right after a match
    go_cycle();
    if_valid = 1; if_pc = 32'h100;
    go_cycle();
    cpu_rstn = 1'b0;
    csr_addr = 12'h7A2; valid_mcsr_rd = 1;
    push(1, 0, "arst_hit", 0); push(2, 0, "arst_idx", 0);
    push(0, 0, "arst_tdata2", 0);
    go_cycle();
    cpu_rstn = 1'b1;
    for (int t = 0; t < NT; t++) begin
      csr_wr(12'h7A0, t, 0, 0);
      csr_rd(12'h7A2, 32'h0, "post_rst_tdata2");
    end

    repeat (3) go_cycle();
    if (sb_q.size() != 0) check_val("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
